// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch core and its digit counters:
//   - BCD digit width and the two wrap limits (9 for decimal digits, 5 for tens of seconds)
//   - FSM state encoding, kept as plain constants for legacy tools
//   - display record whose field order is the packing order of disp_digits
// No ports (package).
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] WRAP_NINE = 4'd9;
  localparam logic [DIGIT_W-1:0] WRAP_FIVE = 4'd5;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RUNNING = 3'd1;
  localparam state_t ST_PAUSED  = 3'd2;
  localparam state_t ST_LAP     = 3'd3;
  localparam state_t ST_OVF     = 3'd4;

  // First field lands in the most significant nibble of the 24-bit bus.
  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_u;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_u;
    logic [DIGIT_W-1:0] cs_t;
    logic [DIGIT_W-1:0] cs_u;
  } disp_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter
// One BCD digit of the time chain. Counts 0..WRAP and wraps back to 0.
// Ports:
//   clk    - system clock, posedge
//   reset  - synchronous active-high reset
//   clr    - synchronous clear to 0
//   inc    - advance by one this cycle
//   value  - current digit
//   carry  - combinational, high when inc wraps the digit (feeds the next digit's inc)
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] WRAP = WRAP_NINE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] value,
  output logic               carry
);

  // Carry is combinational so the whole chain ripples within the inc cycle.
  assign carry = inc && (value == WRAP);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == WRAP) ? '0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
// mm:ss.cc BCD stopwatch driven by rising edges of the divided tick.
// Ports:
//   clk_in      - system clock, posedge
//   reset       - synchronous active-high reset
//   tick_in     - divided square wave (same clock domain)
//   start_stop  - pulse, toggles run/pause
//   lap         - pulse, freezes/releases the display
//   clear       - pulse, zeroes the count
//   disp_digits - {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
//   running     - high in RUNNING and LAP
//   lap_active  - high while display is frozen
//   overflow    - sticky saturation flag
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int MAX_MIN  = 59
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] disp_digits,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam logic [9:0]         PRESC_LAST = 10'(PRESCALE - 1);
  localparam logic [DIGIT_W-1:0] MIN_T_MAX  = 4'(MAX_MIN / 10);
  localparam logic [DIGIT_W-1:0] MIN_U_MAX  = 4'(MAX_MIN % 10);

  state_t             state;
  state_t             next_state;
  logic               next_lap;
  logic               tick_q;
  logic [9:0]         presc;
  logic [DIGIT_W-1:0] min_t;
  logic [DIGIT_W-1:0] min_u;
  logic [DIGIT_W-1:0] sec_t;
  logic [DIGIT_W-1:0] sec_u;
  logic [DIGIT_W-1:0] cs_t;
  logic [DIGIT_W-1:0] cs_u;
  logic               cs_u_carry;
  logic               cs_t_carry;
  logic               sec_u_carry;
  logic               sec_t_carry;
  disp_t              disp_q;

  logic tick_rise;
  logic counting;
  logic tick_cnt;
  logic inc;
  logic at_max;
  logic cnt_inc;
  logic saturate;

  // The rise is taken straight from tick_in so the count moves on the same
  // edge that loads tick_q; a tick coinciding with clear is dropped.
  assign tick_rise = tick_in && !tick_q;
  assign counting  = (state == ST_RUNNING) || (state == ST_LAP);
  assign tick_cnt  = tick_rise && counting && !clear;
  assign inc       = tick_cnt && (presc == PRESC_LAST);

  assign at_max = (min_t == MIN_T_MAX) && (min_u == MIN_U_MAX) &&
                  (sec_t == WRAP_FIVE) && (sec_u == WRAP_NINE) &&
                  (cs_t == WRAP_NINE) && (cs_u == WRAP_NINE);

  // At the top of the range the increment is swallowed rather than wrapped.
  assign cnt_inc  = inc && !at_max;
  assign saturate = inc && at_max;

  bcd_digit_counter #(.WRAP(WRAP_NINE)) u_cs_u (
    .clk(clk_in), .reset(reset), .clr(clear), .inc(cnt_inc),
    .value(cs_u), .carry(cs_u_carry)
  );

  bcd_digit_counter #(.WRAP(WRAP_NINE)) u_cs_t (
    .clk(clk_in), .reset(reset), .clr(clear), .inc(cs_u_carry),
    .value(cs_t), .carry(cs_t_carry)
  );

  bcd_digit_counter #(.WRAP(WRAP_NINE)) u_sec_u (
    .clk(clk_in), .reset(reset), .clr(clear), .inc(cs_t_carry),
    .value(sec_u), .carry(sec_u_carry)
  );

  bcd_digit_counter #(.WRAP(WRAP_FIVE)) u_sec_t (
    .clk(clk_in), .reset(reset), .clr(clear), .inc(sec_u_carry),
    .value(sec_t), .carry(sec_t_carry)
  );

  // Control decode: clear beats start_stop beats lap; saturation overrides
  // whatever the controls chose because the count can no longer advance.
  always_comb begin
    next_state = state;
    next_lap   = lap_active;
    if (clear) begin
      next_state = ST_IDLE;
      next_lap   = 1'b0;
    end else if (start_stop) begin
      case (state)
        ST_IDLE:    next_state = ST_RUNNING;
        ST_RUNNING: next_state = ST_PAUSED;
        ST_LAP:     next_state = ST_PAUSED;
        ST_PAUSED:  next_state = lap_active ? ST_LAP : ST_RUNNING;
        default:    next_state = state;
      endcase
    end else if (lap) begin
      case (state)
        ST_RUNNING: begin
          next_state = ST_LAP;
          next_lap   = 1'b1;
        end
        ST_LAP: begin
          next_state = ST_RUNNING;
          next_lap   = 1'b0;
        end
        ST_PAUSED: next_lap = 1'b0;
        default:   next_lap = lap_active;
      endcase
    end
    if (!clear && saturate) begin
      next_state = ST_OVF;
    end
  end

  // Registered state, prescaler, minutes pair and display. The display copies
  // the live count every cycle unless the lap freeze is in effect.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= ST_IDLE;
      lap_active <= 1'b0;
      running    <= 1'b0;
      overflow   <= 1'b0;
      tick_q     <= 1'b0;
      presc      <= '0;
      min_t      <= '0;
      min_u      <= '0;
      disp_q     <= '0;
    end else begin
      tick_q     <= tick_in;
      state      <= next_state;
      lap_active <= next_lap;
      running    <= (next_state == ST_RUNNING) || (next_state == ST_LAP);
      if (clear) begin
        presc    <= '0;
        min_t    <= '0;
        min_u    <= '0;
        overflow <= 1'b0;
        disp_q   <= '0;
      end else begin
        if (tick_cnt) begin
          presc <= (presc == PRESC_LAST) ? '0 : presc + 10'd1;
        end
        // Minutes never pass MAX_MIN because saturation gates the chain.
        if (sec_t_carry) begin
          if (min_u == WRAP_NINE) begin
            min_u <= '0;
            min_t <= min_t + 4'd1;
          end else begin
            min_u <= min_u + 4'd1;
          end
        end
        if (saturate) begin
          overflow <= 1'b1;
        end
        if (!lap_active) begin
          disp_q <= '{min_t: min_t, min_u: min_u, sec_t: sec_t,
                      sec_u: sec_u, cs_t: cs_t, cs_u: cs_u};
        end
      end
    end
  end

  assign disp_digits = disp_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
// Three stopwatch instances: A (PRESCALE=1, MAX_MIN=59), B (PRESCALE=1,
// MAX_MIN=1) for saturation, C (PRESCALE=4, MAX_MIN=59) for the prescaler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in    [3];
  logic        start_stop [3];
  logic        lap        [3];
  logic        clear      [3];
  logic [23:0] disp       [3];
  logic        running    [3];
  logic        lap_active [3];
  logic        overflow   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.PRESCALE(1), .MAX_MIN(59)) dut_a (
    .clk_in(clk), .reset(reset), .tick_in(tick_in[0]), .start_stop(start_stop[0]),
    .lap(lap[0]), .clear(clear[0]), .disp_digits(disp[0]), .running(running[0]),
    .lap_active(lap_active[0]), .overflow(overflow[0])
  );

  stopwatch_core #(.PRESCALE(1), .MAX_MIN(1)) dut_b (
    .clk_in(clk), .reset(reset), .tick_in(tick_in[1]), .start_stop(start_stop[1]),
    .lap(lap[1]), .clear(clear[1]), .disp_digits(disp[1]), .running(running[1]),
    .lap_active(lap_active[1]), .overflow(overflow[1])
  );

  stopwatch_core #(.PRESCALE(4), .MAX_MIN(59)) dut_c (
    .clk_in(clk), .reset(reset), .tick_in(tick_in[2]), .start_stop(start_stop[2]),
    .lap(lap[2]), .clear(clear[2]), .disp_digits(disp[2]), .running(running[2]),
    .lap_active(lap_active[2]), .overflow(overflow[2])
  );

  // One control cycle (pulses plus optional coincident tick rise), then a
  // number of tick rising edges, then the expected outputs.
  typedef struct {
    string       name;
    bit          ss;
    bit          lp;
    bit          clr;
    bit          rise_with;
    int          ticks;
    logic [23:0] exp_disp;
    bit          exp_run;
    bit          exp_lap;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int d, input int n);
    repeat (n) begin
      tick_in[d] = 1'b1;
      @(negedge clk);
      tick_in[d] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input int d, input bit ss, input bit lp, input bit clr, input bit rise);
    start_stop[d] = ss;
    lap[d]        = lp;
    clear[d]      = clr;
    tick_in[d]    = rise;
    @(negedge clk);
    start_stop[d] = 1'b0;
    lap[d]        = 1'b0;
    clear[d]      = 1'b0;
    tick_in[d]    = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input int d, input logic [23:0] e_disp,
                              input bit e_run, input bit e_lap, input bit e_ovf);
    check_val({name, ".disp"}, disp[d], e_disp);
    check_val({name, ".running"}, 24'(running[d]), 24'(e_run));
    check_val({name, ".lap_active"}, 24'(lap_active[d]), 24'(e_lap));
    check_val({name, ".overflow"}, 24'(overflow[d]), 24'(e_ovf));
  endtask

  task automatic apply_stimulus(input int d, input vec_t v);
    pulse(d, v.ss, v.lp, v.clr, v.rise_with);
    tick(d, v.ticks);
    idle(2);
    check_output(v.name, d, v.exp_disp, v.exp_run, v.exp_lap, v.exp_ovf);
  endtask

  initial begin
    //             name          ss lp clr rw ticks disp        run lap ovf
    vecs[0]  = '{"start_100",    1, 0, 0, 0, 100,  24'h000100, 1, 0, 0};
    vecs[1]  = '{"pause_hold",   1, 0, 0, 0, 50,   24'h000100, 0, 0, 0};
    vecs[2]  = '{"resume_rise",  1, 0, 0, 1, 1,    24'h000101, 1, 0, 0};
    vecs[3]  = '{"pause_rise",   1, 0, 0, 1, 0,    24'h000102, 0, 0, 0};
    vecs[4]  = '{"clear_all",    1, 0, 1, 1, 0,    24'h000000, 0, 0, 0};
    vecs[5]  = '{"idle_lap",     0, 1, 0, 0, 0,    24'h000000, 0, 0, 0};
    vecs[6]  = '{"run_5",        1, 0, 0, 0, 5,    24'h000005, 1, 0, 0};
    vecs[7]  = '{"lap_freeze",   0, 1, 0, 0, 20,   24'h000005, 1, 1, 0};
    vecs[8]  = '{"lap_release",  0, 1, 0, 0, 0,    24'h000025, 1, 0, 0};
    vecs[9]  = '{"lap_again",    0, 1, 0, 0, 3,    24'h000025, 1, 1, 0};
    vecs[10] = '{"lap_pause",    1, 0, 0, 0, 4,    24'h000025, 0, 1, 0};
    vecs[11] = '{"pause_to_lap", 1, 0, 0, 0, 2,    24'h000025, 1, 1, 0};
    vecs[12] = '{"lap_pause2",   1, 0, 0, 0, 0,    24'h000025, 0, 1, 0};
    vecs[13] = '{"paused_rel",   0, 1, 0, 0, 0,    24'h000030, 0, 0, 0};
    vecs[14] = '{"run_5999",     1, 0, 0, 0, 5969, 24'h005999, 1, 0, 0};
    vecs[15] = '{"carry_min",    0, 0, 0, 0, 1,    24'h010000, 1, 0, 0};
    vecs[16] = '{"ss_beats_lap", 1, 1, 0, 0, 0,    24'h010000, 0, 0, 0};

    for (int d = 0; d < 3; d++) begin
      tick_in[d]    = 1'b0;
      start_stop[d] = 1'b0;
      lap[d]        = 1'b0;
      clear[d]      = 1'b0;
    end
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("reset%0d", d), d, 24'h000000, 0, 0, 0);
    end

    for (int i = 0; i < 17; i++) begin
      apply_stimulus(0, vecs[i]);
    end

    // Latency: display lags the count by one cycle.
    pulse(0, 1, 0, 0, 0);
    tick_in[0] = 1'b1;
    @(negedge clk);
    check_val("latency_first_edge", disp[0], 24'h010000);
    tick_in[0] = 1'b0;
    @(negedge clk);
    check_val("latency_second_edge", disp[0], 24'h010001);
    check_val("latency_running", 24'(running[0]), 24'd1);

    // Saturation with MAX_MIN=1.
    pulse(1, 1, 0, 0, 0);
    tick(1, 11999);
    idle(2);
    check_output("b_top", 1, 24'h015999, 1, 0, 0);
    tick(1, 1);
    idle(2);
    check_output("b_saturate", 1, 24'h015999, 0, 0, 1);
    pulse(1, 1, 0, 0, 0);
    tick(1, 3);
    idle(2);
    check_output("b_ovf_ss_ignored", 1, 24'h015999, 0, 0, 1);
    pulse(1, 0, 1, 0, 0);
    idle(2);
    check_output("b_ovf_lap_ignored", 1, 24'h015999, 0, 0, 1);
    pulse(1, 0, 0, 1, 0);
    idle(1);
    check_output("b_clear", 1, 24'h000000, 0, 0, 0);

    // Prescaler of 4 and a long high level counting as one edge.
    pulse(2, 1, 0, 0, 0);
    tick(2, 8);
    idle(2);
    check_output("c_8_edges", 2, 24'h000002, 1, 0, 0);
    tick_in[2] = 1'b1;
    idle(1000);
    tick_in[2] = 1'b0;
    idle(3);
    check_output("c_hold", 2, 24'h000002, 1, 0, 0);
    tick(2, 2);
    idle(2);
    check_output("c_hold_plus2", 2, 24'h000002, 1, 0, 0);
    tick(2, 1);
    idle(2);
    check_output("c_hold_plus3", 2, 24'h000003, 1, 0, 0);
    tick(2, 2);

    // Reset mid-count must leave no residue, including the prescaler.
    tick(0, 7);
    idle(2);
    check_val("a_before_reset", disp[0], 24'h010008);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("midreset%0d", d), d, 24'h000000, 0, 0, 0);
    end
    pulse(0, 1, 0, 0, 0);
    tick(0, 1);
    idle(2);
    check_output("a_after_reset", 0, 24'h000001, 1, 0, 0);
    pulse(2, 1, 0, 0, 0);
    tick(2, 3);
    idle(2);
    check_output("c_after_reset3", 2, 24'h000000, 1, 0, 0);
    tick(2, 1);
    idle(2);
    check_output("c_after_reset4", 2, 24'h000001, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
